rptr_handler: RTL
=================

# rptr_handler

Read-side pointer handler for the asynchronous FIFO, in the read clock domain. It advances the binary and Gray read pointers on accepted reads and derives a registered `empty` flag from the write pointer after it has been synchronised into this domain. It also converts that synchronised Gray write pointer to binary to produce an occupancy count and an almost-empty flag, and it flags reads attempted while empty. It pairs with the write-side pointer handler: `g_rptr` feeds the write-domain synchroniser and `b_rptr[PTR_WIDTH-1:0]` addresses the FIFO memory read port.

## Interface
- `PTR_WIDTH`, 3: address width; FIFO depth = 2^PTR_WIDTH; pointers are PTR_WIDTH+1 bits (wrap bit in the MSB).
- `AE_THRESH`, 1: almost-empty threshold in entries, 0..2^PTR_WIDTH.

Ports (one clock; reset is asynchronous and active-low):
- `rclk`  input  1  read-domain clock; all state updates on the rising edge.
- `rrst_n`  input  1  asynchronous active-low reset.
- `r_en`  input  1  read request.
- `g_wptr_sync`  input  PTR_WIDTH+1  Gray write pointer, already synchronised to `rclk`.
- `b_rptr`  output  PTR_WIDTH+1  binary read pointer (registered).
- `g_rptr`  output  PTR_WIDTH+1  Gray read pointer (registered).
- `empty`  output  1  FIFO empty (registered).
- `almost_empty`  output  1  occupancy <= AE_THRESH (registered).
- `rd_count`  output  PTR_WIDTH+1  occupancy as seen by the read side (registered).
- `underflow`  output  1  one-cycle pulse: read requested while empty.

## Operation
- Accepted read: `rd_acc = r_en & ~empty`.
- `b_rptr_next = b_rptr + rd_acc`, modulo 2^(PTR_WIDTH+1); `g_rptr_next = (b_rptr_next >> 1) ^ b_rptr_next`.
- `empty_next = (g_rptr_next == g_wptr_sync)`. Full-Gray equality, including the MSB.
- Gray-to-binary of the write pointer: `b_wptr_s[PTR_WIDTH] = g_wptr_sync[PTR_WIDTH]`; `b_wptr_s[i] = b_wptr_s[i+1] ^ g_wptr_sync[i]`, for i from PTR_WIDTH-1 down to 0.
- `count_next = b_wptr_s - b_rptr_next`, modulo 2^(PTR_WIDTH+1). The range is 0..2^PTR_WIDTH.
- `almost_empty_next = (count_next <= AE_THRESH)`.
- `underflow_next = r_en & empty`. The pointers hold and the request is dropped.
- Reset values: `b_rptr` = 0, `g_rptr` = 0, `empty` = 1, `almost_empty` = 1, `rd_count` = 0, `underflow` = 0.
- Asserting reset mid-operation clears everything to the reset values immediately, without waiting for a clock edge. Any in-flight read is discarded.
- Wrap-around: the pointer MSB toggles every 2^PTR_WIDTH accepted reads. The pointers return to 0 after 2^(PTR_WIDTH+1) reads, and `g_rptr` changes exactly one bit per increment.

## Timing
- All outputs are registered and update one `rclk` edge after the inputs that cause them.
- Read latency: the pointer advances on the same edge that samples `r_en`. The memory is addressed by `b_rptr` before the edge.
- The last read and `empty`:
  - When the last entry is read, `empty` asserts on that same edge, since it is computed from `g_rptr_next`.
  - A further `r_en` on the following cycle is rejected.
- Simultaneous events: if `g_wptr_sync` advances in the same cycle as the last read, `empty` stays 0.
- After `g_wptr_sync` changes, `empty`, `rd_count` and `almost_empty` deassert or update on the next edge.
- Occupancy is pessimistic, because of synchroniser delay. It never over-reports.

## Configuration
- Macro: `RPTR_LEVEL_EN`.
- Defined: the Gray-to-binary converter, the subtractor and the `rd_count`/`almost_empty` registers are built as described above.
- Undefined: that logic is omitted. `rd_count` is tied to 0 and `almost_empty` is tied to `empty`.
- The pointers, `empty` and `underflow` are unaffected either way.

## Test plan
All cases use PTR_WIDTH=3 and AE_THRESH=1.
- **Reset:** hold `rrst_n`=0 with `r_en`=1 and `g_wptr_sync`=4'b0110 → `b_rptr`=0, `g_rptr`=0, `empty`=1, `almost_empty`=1, `rd_count`=0, `underflow`=0. Check also asynchronously, before any `rclk` edge.
- **Basic read:** set `g_wptr_sync`=4'b0010 (3 entries) → next edge `empty`=0, `rd_count`=3, `almost_empty`=0. Then 3 reads → `g_rptr` goes 0001, 0011, 0010; `rd_count` goes 2, 1, 0; `almost_empty`=1 after the 2nd read; `empty`=1 on the 3rd edge.
- **Underflow:** `r_en`=1 while empty for 2 cycles → `b_rptr` holds; `underflow`=1 for each of those 2 cycles, 0 afterwards.
- **Full and wrap:** `g_wptr_sync`=4'b1100 (8 entries) → `rd_count`=8. 8 reads → `b_rptr`=4'b1000, `g_rptr`=4'b1100, `empty`=1. Set `g_wptr_sync`=4'b0000 and do 8 more reads → `b_rptr` wraps to 0000 and `empty`=1.
- **Simultaneous:** with 1 entry (`g_wptr_sync`=4'b0001), read while `g_wptr_sync` steps to 4'b0011 on the same cycle → `empty` stays 0, `rd_count`=1, `b_rptr`=1.
- **Reset mid-stream:** assert `rrst_n`=0 after 5 of 8 reads → all outputs return to reset values. After release, `empty`=0 on the next edge while `g_wptr_sync`≠0.

Source files
------------

// File: rtl/rptr_handler_if.sv
// Read-side FIFO pointer bundle: request/synchronised write pointer in, pointers and flags out.
// The master modport is the consumer side and the slave modport is rptr_handler.
interface rptr_handler_if #(
  parameter int PTR_WIDTH = 3
);
  logic                 r_en;
  logic [PTR_WIDTH:0]   g_wptr_sync;
  logic [PTR_WIDTH:0]   b_rptr;
  logic [PTR_WIDTH:0]   g_rptr;
  logic                 empty;
  logic                 almost_empty;
  logic [PTR_WIDTH:0]   rd_count;
  logic                 underflow;

  modport master (
    output r_en, g_wptr_sync,
    input  b_rptr, g_rptr, empty, almost_empty, rd_count, underflow
  );

  modport slave (
    input  r_en, g_wptr_sync,
    output b_rptr, g_rptr, empty, almost_empty, rd_count, underflow
  );
endinterface

// File: rtl/rptr_handler.sv
// Async-FIFO read pointer handler: binary/Gray read pointers, empty and underflow flags.
// Occupancy (rd_count/almost_empty) is built only when RPTR_LEVEL_EN is defined.
module rptr_handler #(
  parameter int PTR_WIDTH = 3,
  parameter int AE_THRESH = 1
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  rptr_handler_if.slave        rd_if
);
  logic [PTR_WIDTH:0] b_rptr_q, b_rptr_d;
  logic [PTR_WIDTH:0] g_rptr_q, g_rptr_d;
  logic               empty_q, empty_d;
  logic               underflow_q, underflow_d;
  logic               rd_acc;

  always_comb begin
    rd_acc      = rd_if.r_en & ~empty_q;
    b_rptr_d    = b_rptr_q + {{PTR_WIDTH{1'b0}}, rd_acc};
    g_rptr_d    = (b_rptr_d >> 1) ^ b_rptr_d;
    // Empty is decided from the post-increment pointer so the last read flags empty on its own edge.
    empty_d     = (g_rptr_d == rd_if.g_wptr_sync);
    underflow_d = rd_if.r_en & empty_q;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      b_rptr_q    <= '0;
      g_rptr_q    <= '0;
      empty_q     <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      b_rptr_q    <= b_rptr_d;
      g_rptr_q    <= g_rptr_d;
      empty_q     <= empty_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_if.b_rptr    = b_rptr_q;
  assign rd_if.g_rptr    = g_rptr_q;
  assign rd_if.empty     = empty_q;
  assign rd_if.underflow = underflow_q;

`ifdef RPTR_LEVEL_EN
  localparam logic [PTR_WIDTH:0] AE_T = (PTR_WIDTH+1)'(AE_THRESH);

  logic [PTR_WIDTH:0] b_wptr_s;
  logic [PTR_WIDTH:0] rd_count_q, rd_count_d;
  logic               almost_empty_q, almost_empty_d;

  always_comb begin
    for (int i = 0; i <= PTR_WIDTH; i++) begin
      b_wptr_s[i] = ^(rd_if.g_wptr_sync >> i);
    end
    rd_count_d     = b_wptr_s - b_rptr_d;
    almost_empty_d = (rd_count_d <= AE_T);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_count_q     <= '0;
      almost_empty_q <= 1'b1;
    end else begin
      rd_count_q     <= rd_count_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign rd_if.rd_count     = rd_count_q;
  assign rd_if.almost_empty = almost_empty_q;
`else
  assign rd_if.rd_count     = '0;
  assign rd_if.almost_empty = empty_q;
`endif
endmodule
